// File: rtl/spi_xfer_pkg.sv
// -----------------------------------------------------------------------------
// spi_xfer_pkg
// Shared types and constants for the SPI byte shift engine.
//   - xfer_state_e : engine state (IDLE, SHIFT, DONE)
//   - SPI_BITS     : bits per transfer
//   - SPI_EDGES    : SCK edges per transfer (two per bit)
//   - first_bit / shift_on : serialiser helpers honouring the bit order
// -----------------------------------------------------------------------------
package spi_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } xfer_state_e;

    localparam int SPI_BITS  = 8;
    localparam int SPI_EDGES = 2 * SPI_BITS;

    // Bit that leaves the shift register first for the selected order.
    function automatic logic first_bit(input logic [SPI_BITS-1:0] d, input logic lsb);
        return lsb ? d[0] : d[SPI_BITS-1];
    endfunction

    // Shift register contents after the current head bit has been consumed.
    function automatic logic [SPI_BITS-1:0] shift_on(input logic [SPI_BITS-1:0] d, input logic lsb);
        return lsb ? {1'b0, d[SPI_BITS-1:1]} : {d[SPI_BITS-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/spi_sck_div.sv
// -----------------------------------------------------------------------------
// spi_sck_div
// SCK half-period down-counter. Loaded with 'period' on 'load'; while 'run'
// is high it counts down and raises 'strike' for one cycle when it reaches
// zero, reloading 'period' in the same cycle.
// Ports:
//   clk, rst_n (async active-low), clr (sync clear)
//   load   : start a new count from 'period'
//   run    : counting enabled
//   period : half-period minus one
//   strike : one-cycle SCK edge request
// -----------------------------------------------------------------------------
module spi_sck_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] period,
    output logic             strike
);

    logic [DIV_W-1:0] cnt_r;

    // Edge request when the running counter has expired.
    always_comb begin
        strike = run && (cnt_r == {DIV_W{1'b0}});
    end

    // Counter: load/reload on start or expiry, otherwise count down while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (load || strike) begin
            cnt_r <= period;
        end else if (run) begin
            cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/spi_xfer_engine.sv
// -----------------------------------------------------------------------------
// spi_xfer_engine
// Byte-serial SPI master shift engine between the TX and RX FIFOs. Pops a
// byte, shifts it out on mosi_o while sampling miso_i in any CPOL/CPHA mode,
// then pushes the received byte (or flags an overrun when the RX FIFO is full).
// Optional feature macro: SPI_XFER_LSBF_EN adds the 'lsbf' port (LSB-first).
// Ports:
//   clk, rst_n (async active-low), clr (sync soft clear), enable (SPE)
//   cpol, cpha, div      : mode and SCK half-period (div+1 clks), latched at load
//   tx_empty, tx_dout    : TX FIFO status/head;  tx_re : pop strobe (combinational)
//   rx_full              : RX FIFO status;  rx_din/rx_we : received byte / push
//   sck_o, mosi_o, miso_i: SPI lines
//   busy, done, rx_ovr   : status strobes
//   lsbf                 : LSB-first select (SPI_XFER_LSBF_EN builds only)
// -----------------------------------------------------------------------------
module spi_xfer_engine
    import spi_xfer_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                enable,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [DIV_W-1:0]    div,
    input  logic                tx_empty,
    input  logic [SPI_BITS-1:0] tx_dout,
    output logic                tx_re,
    input  logic                rx_full,
    output logic [SPI_BITS-1:0] rx_din,
    output logic                rx_we,
    output logic                sck_o,
    output logic                mosi_o,
    input  logic                miso_i,
    output logic                busy,
    output logic                done,
    output logic                rx_ovr
`ifdef SPI_XFER_LSBF_EN
    ,
    input  logic                lsbf
`endif
);

    localparam logic [3:0] LAST_EDGE = 4'(SPI_EDGES - 1);

    xfer_state_e         state_r, state_nxt_s;
    logic                cpol_r, cpha_r, lsbf_r;
    logic [DIV_W-1:0]    div_r;
    logic [3:0]          edge_cnt_r;
    logic [SPI_BITS-1:0] tx_sr_r, rx_sr_r, rx_din_r, rx_next_s;
    logic                sck_r, mosi_r;
    logic                lsbf_s, abort_s, pop_s, strike_s, sample_s, last_edge_s;
    logic [DIV_W-1:0]    period_s;

`ifdef SPI_XFER_LSBF_EN
    assign lsbf_s = lsbf;
`else
    assign lsbf_s = 1'b0;
`endif

    assign sck_o  = sck_r;
    assign mosi_o = mosi_r;
    assign rx_din = rx_din_r;

    // Control decodes; clr blocks a pop issued in the same cycle.
    always_comb begin
        abort_s     = clr || !enable;
        pop_s       = (state_r == IDLE) && enable && !tx_empty && !clr;
        // Leading (even) edges sample when cpha=0; trailing (odd) edges when cpha=1.
        sample_s    = strike_s && (!edge_cnt_r[0] ^ cpha_r);
        last_edge_s = strike_s && (edge_cnt_r == LAST_EDGE);
        rx_next_s   = lsbf_r ? {miso_i, rx_sr_r[SPI_BITS-1:1]} : {rx_sr_r[SPI_BITS-2:0], miso_i};
        // A fresh byte counts from the live div; reloads use the latched copy.
        period_s    = pop_s ? div : div_r;
    end

    spi_sck_div #(.DIV_W(DIV_W)) u_sck_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .load   (pop_s),
        .run    (state_r == SHIFT),
        .period (period_s),
        .strike (strike_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and strobes; an abort in SHIFT/DONE suppresses every completion strobe.
    always_comb begin
        state_nxt_s = state_r;
        tx_re       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        rx_we       = 1'b0;
        rx_ovr      = 1'b0;
        case (state_r)
            IDLE: begin
                tx_re = pop_s;
                if (pop_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (abort_s) begin
                    state_nxt_s = IDLE;
                end else if (last_edge_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                busy        = 1'b1;
                state_nxt_s = IDLE;
                if (abort_s) begin
                    done = 1'b0;
                end else begin
                    done   = 1'b1;
                    rx_we  = !rx_full;
                    rx_ovr = rx_full;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Datapath: load on pop, idle/abort parks SCK at cpol, each strike moves one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            lsbf_r     <= 1'b0;
            div_r      <= {DIV_W{1'b0}};
            edge_cnt_r <= 4'd0;
            tx_sr_r    <= {SPI_BITS{1'b0}};
            rx_sr_r    <= {SPI_BITS{1'b0}};
            rx_din_r   <= {SPI_BITS{1'b0}};
            sck_r      <= 1'b0;
            mosi_r     <= 1'b0;
        end else if (pop_s) begin
            cpol_r     <= cpol;
            cpha_r     <= cpha;
            lsbf_r     <= lsbf_s;
            div_r      <= div;
            edge_cnt_r <= 4'd0;
            rx_sr_r    <= {SPI_BITS{1'b0}};
            sck_r      <= cpol;
            // cpha=0 needs the first bit on the wire before the first (sampling) edge.
            if (!cpha) begin
                mosi_r  <= first_bit(tx_dout, lsbf_s);
                tx_sr_r <= shift_on(tx_dout, lsbf_s);
            end else begin
                mosi_r  <= mosi_r;
                tx_sr_r <= tx_dout;
            end
        end else if ((state_r == IDLE) || abort_s) begin
            sck_r <= cpol;
        end else if (strike_s) begin
            edge_cnt_r <= edge_cnt_r + 4'd1;
            sck_r      <= last_edge_s ? cpol_r : !sck_r;
            if (sample_s) begin
                rx_sr_r <= rx_next_s;
            end else begin
                mosi_r  <= first_bit(tx_sr_r, lsbf_r);
                tx_sr_r <= shift_on(tx_sr_r, lsbf_r);
            end
            if (last_edge_s) begin
                rx_din_r <= sample_s ? rx_next_s : rx_sr_r;
            end else begin
                rx_din_r <= rx_din_r;
            end
        end else begin
            sck_r <= sck_r;
        end
    end

endmodule

// File: tb/tb_spi_xfer_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_xfer_engine
// Self-checking bench for spi_xfer_engine. A TX FIFO model feeds bytes, a
// behavioural SPI slave (or MOSI->MISO loopback) answers, and every transfer
// is checked against the SPI rules: bit order on MOSI at sampling edges, 16
// SCK edges, completion latency 16(div+1)+1, byte spacing, overrun and aborts.
// Optional feature macro: SPI_XFER_LSBF_EN.
// -----------------------------------------------------------------------------
module tb_spi_xfer_engine;

    localparam int DIV_W = 8;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             clr      = 1'b0;
    logic             enable   = 1'b0;
    logic             cpol     = 1'b0;
    logic             cpha     = 1'b0;
    logic [DIV_W-1:0] div      = 8'd0;
    logic             tx_empty = 1'b1;
    logic [7:0]       tx_dout  = 8'd0;
    logic             rx_full  = 1'b0;
    logic             lsbf     = 1'b0;
    logic             loopback = 1'b1;
    logic             sl_miso  = 1'b0;
    logic             tx_re, rx_we, sck_o, mosi_o, miso_i, busy, done, rx_ovr;
    logic [7:0]       rx_din;

    logic [7:0] txb [4];
    logic [7:0] slb [4];

    int checks = 0;
    int errors = 0;

    assign miso_i = loopback ? mosi_o : sl_miso;

    always #5 clk = ~clk;

    spi_xfer_engine #(.DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .enable   (enable),
        .cpol     (cpol),
        .cpha     (cpha),
        .div      (div),
        .tx_empty (tx_empty),
        .tx_dout  (tx_dout),
        .tx_re    (tx_re),
        .rx_full  (rx_full),
        .rx_din   (rx_din),
        .rx_we    (rx_we),
        .sck_o    (sck_o),
        .mosi_o   (mosi_o),
        .miso_i   (miso_i),
        .busy     (busy),
        .done     (done),
        .rx_ovr   (rx_ovr)
`ifdef SPI_XFER_LSBF_EN
        ,
        .lsbf     (lsbf)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bit k (in transmission order) of a byte.
    function automatic logic ser_bit(input logic [7:0] b, input int k, input logic lsb);
        return lsb ? b[k] : b[7-k];
    endfunction

    // Run n queued bytes through the engine and check each against the SPI rules.
    task automatic run_bytes(input int n, input int d, input logic pol, input logic pha,
                             input logic lsb, input logic loop, input logic full);
        int   idx       = 0;
        bit   pend      = 0;
        int   ndone     = 0;
        int   edges     = 0;
        int   cyc       = 0;
        int   t0        = 0;
        int   prev_t0   = -1;
        int   last_done = -1;
        int   cur       = 0;
        int   j;
        bit   active    = 0;
        logic prev_sck;
        cpol = pol; cpha = pha; div = d[7:0]; lsbf = lsb;
        loopback = loop; rx_full = full; enable = 1'b1; tx_empty = 1'b1; sl_miso = 1'b0;
        repeat (2) @(negedge clk);
        check_val("sck_idle_level", sck_o, pol);
        prev_sck = sck_o;
        while (ndone < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                idx++;
                pend = 0;
            end
            tx_empty = (idx >= n);
            tx_dout  = txb[(idx < n) ? idx : 0];
            #1;
            if (sck_o !== prev_sck) begin
                j = edges / 2;
                if (active && (((edges % 2) == 0) == (pha == 1'b0))) begin
                    check_val("mosi_at_sample", mosi_o, ser_bit(txb[cur], j, lsb));
                end else if (active && !loop) begin
                    j = pha ? edges / 2 : (edges + 1) / 2;
                    if (j < 8) sl_miso = ser_bit(slb[cur], j, lsb);
                end
                edges++;
            end
            prev_sck = sck_o;
            if (tx_re === 1'b1) begin
                check_val("edges_while_idle", edges, 0);
                check_val("busy_at_pop", busy, 0);
                if (ndone > 0) begin
                    check_val("pop_after_done", cyc - last_done, 1);
                    check_val("pop_spacing", cyc - prev_t0, 16 * (d + 1) + 2);
                end
                cur = idx; t0 = cyc; prev_t0 = cyc; pend = 1; active = 1;
                if (!loop && !pha) sl_miso = ser_bit(slb[cur], 0, lsb);
            end else if (done === 1'b1) begin
                check_val("done_latency", cyc - t0, 16 * (d + 1) + 1);
                check_val("edge_count", edges, 16);
                check_val("rx_we", rx_we, !full);
                check_val("rx_ovr", rx_ovr, full);
                if (!full) check_val("rx_din", rx_din, loop ? txb[cur] : slb[cur]);
                check_val("sck_after_byte", sck_o, pol);
                check_val("busy_in_done", busy, 1);
                ndone++; last_done = cyc; active = 0; edges = 0;
            end else begin
                check_val("stray_strobe", {rx_we, rx_ovr, done}, 0);
                if (active) check_val("busy_in_shift", busy, 1);
            end
        end
        if (ndone < n) check_val("timeout_bytes_done", ndone, n);
        tx_empty = 1'b1;
        rx_full  = 1'b0;
        @(negedge clk);
        check_val("busy_after_run", busy, 0);
    endtask

    // Abort a byte mid-shift by clr (0), reset (1) or enable drop (2), then transfer cleanly.
    task automatic abort_test(input int kind);
        txb[0] = 8'($urandom);
        cpol = 1'b0; cpha = 1'b0; div = 8'd0; loopback = 1'b1; enable = 1'b1; rx_full = 1'b0;
        repeat (2) @(negedge clk);
        tx_dout = txb[0]; tx_empty = 1'b0;
        #1;
        check_val("abort_pop", tx_re, 1);
        @(negedge clk);
        tx_empty = 1'b1;
        repeat (7) @(negedge clk);
        if (kind == 0) clr = 1'b1;
        else if (kind == 1) rst_n = 1'b0;
        else enable = 1'b0;
        #1;
        if (kind == 1) begin
            check_val("rst_outputs", {sck_o, mosi_o, tx_re, rx_we, done, rx_ovr, busy}, 0);
            check_val("rst_rx_din", rx_din, 0);
        end else begin
            check_val("abort_cycle_strobes", {done, rx_we, rx_ovr}, 0);
        end
        @(negedge clk);
        #1;
        check_val("abort_idle_busy", busy, 0);
        check_val("abort_strobes", {done, rx_we, rx_ovr}, 0);
        check_val("abort_sck", sck_o, 0);
        clr = 1'b0; rst_n = 1'b1; enable = 1'b1;
        txb[0] = 8'($urandom);
        run_bytes(1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [1:0] mv;
        repeat (3) @(negedge clk);
        check_val("reset_outputs", {sck_o, mosi_o, tx_re, rx_we, done, rx_ovr, busy}, 0);
        check_val("reset_rx_din", rx_din, 0);
        rst_n = 1'b1;

        // Mode 0, div 0, loopback of 0xA5.
        txb[0] = 8'hA5;
        run_bytes(1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Modes 1..3, div 2, send 0x3C while the slave returns 0xC3.
        for (int m = 1; m < 4; m++) begin
            mv = 2'(m);
            txb[0] = 8'h3C;
            slb[0] = 8'hC3;
            run_bytes(1, 2, mv[1], mv[0], 1'b0, 1'b0, 1'b0);
        end

        // Four queued bytes back to back.
        for (int i = 0; i < 4; i++) txb[i] = 8'($urandom);
        run_bytes(4, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // RX FIFO full at completion.
        txb[0] = 8'($urandom);
        run_bytes(1, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        for (int k = 0; k < 3; k++) abort_test(k);

        // clr wins over a pop in the same cycle.
        tx_dout = 8'h5A; tx_empty = 1'b0; clr = 1'b1;
        #1;
        check_val("clr_blocks_pop", tx_re, 0);
        @(negedge clk);
        #1;
        check_val("clr_stays_idle", busy, 0);
        tx_empty = 1'b1; clr = 1'b0;

`ifdef SPI_XFER_LSBF_EN
        txb[0] = 8'h01;
        run_bytes(1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
`endif

        // Randomized transfers.
        for (int r = 0; r < 12; r++) begin
            int   nb;
            int   dv;
            logic lb;
            nb = $urandom_range(1, 3);
            dv = $urandom_range(0, 3);
            lb = 1'b0;
`ifdef SPI_XFER_LSBF_EN
            lb = 1'($urandom_range(0, 1));
`endif
            for (int i = 0; i < 4; i++) begin
                txb[i] = 8'($urandom);
                slb[i] = 8'($urandom);
            end
            run_bytes(nb, dv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lb,
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_xfer_engine.md
# spi_xfer_engine

Byte-serial SPI master shift engine between the 4-entry transmit and receive FIFOs of the SPI core. It pops one byte from the TX FIFO, shifts it out on MOSI while sampling MISO, and pushes the received byte into the RX FIFO. It supports all four CPOL/CPHA modes with a programmable SCK divider and reports completion and overrun.

## Interface
- DIV_W, 8, width of the half-period divider input

- clk  in  1  core clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- clr  in  1  synchronous soft clear, same cycle as FIFO clear
- enable  in  1  core enable (SPE)
- cpol  in  1  SCK idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- div  in  DIV_W  SCK half-period = div+1 clk cycles
- tx_empty  in  1  TX FIFO empty
- tx_dout  in  8  TX FIFO head data, valid while !tx_empty
- tx_re  out  1  TX FIFO pop strobe
- rx_full  in  1  RX FIFO full
- rx_din  out  8  received byte
- rx_we  out  1  RX FIFO push strobe
- sck_o  out  1  SPI clock
- mosi_o  out  1  serial data out
- miso_i  in  1  serial data in
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse per completed byte
- rx_ovr  out  1  one-cycle pulse: byte dropped, RX full
- lsbf  in  1  LSB-first select; present only with SPI_XFER_LSBF_EN

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: sck_o <= cpol each cycle. If enable && !tx_empty, assert tx_re for one cycle, load the shift register from tx_dout in that same cycle, latch cpol/cpha/div, clear the edge count, load the divider with div, and go to SHIFT.
- SHIFT: the divider decrements. When it is 0, toggle sck_o, reload div and increment the edge count (0..15).
  - Even (leading) edges sample miso_i when cpha=0 and shift MOSI when cpha=1.
  - Odd (trailing) edges do the reverse.
  - With cpha=0, bit 7 is on mosi_o from the load cycle onward.
  - After the 16th edge, go to DONE. sck_o then equals cpol again.
- DONE, one cycle, with done=1:
  - If !rx_full: rx_we=1 and rx_din holds the byte.
  - Otherwise: rx_ovr=1, no rx_we, byte discarded.
  - Go to IDLE. Back-to-back bytes are allowed from the next cycle.
- busy=1 in SHIFT and DONE.
- cpol, cpha and div changes during a byte are ignored until the next load.
- clr, or enable deasserted in SHIFT/DONE: abort to IDLE next cycle with no done, rx_we or rx_ovr, and sck_o=cpol. A byte already popped is lost.
- clr has priority over a pop in the same cycle: no tx_re.
- Reset values: state IDLE; sck_o, mosi_o, tx_re, rx_we, done, rx_ovr, busy = 0; rx_din = 0; shift register 0.

## Timing
- tx_re is registered-free (combinational from IDLE state and inputs) so the pop and the data capture occur in the same cycle.
- SCK edges fall at the ends of cycles T0+k(div+1), k=1..16, where T0 is the tx_re cycle.
- done/rx_we/rx_ovr are asserted in cycle T0+16(div+1)+1.
  - div=0: cycle T0+17.
  - div=3: cycle T0+65.
- rx_din is stable from the done cycle until the next done.
- Minimum byte-to-byte spacing is 16(div+1)+2 cycles.

## Configuration
- SPI_XFER_LSBF_EN defined:
  - The lsbf port exists and is latched at load.
  - lsbf=1 shifts bit 0 first on MOSI and assembles received bits LSB-first.
- Not defined: the port is absent and transfers are always MSB-first.
- Timing is identical in both builds.

## Structure
- Package spi_xfer_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - localparam SPI_BITS=8;
  - localparam SPI_EDGES=2*SPI_BITS.
- One sub-module, spi_sck_div: DIV_W down-counter with load/reload producing a one-cycle edge strike. The engine instantiates it once.

## Test plan
- Mode 0, div=0, tx byte 0xA5, MISO loops back MOSI:
  - tx_re once;
  - exactly 16 SCK edges;
  - rx_we with rx_din=0xA5 at T0+17;
  - done pulse;
  - sck_o returns to 0.
- Modes 1/2/3, div=2, tx 0x3C, MISO driven 0xC3 per mode:
  - MOSI bits valid at each sampling edge;
  - rx_din=0xC3 at T0+49;
  - SCK idles at cpol.
- Four bytes queued, div=0:
  - four tx_re at 18-cycle spacing;
  - four rx_we in order;
  - busy high except one IDLE cycle between bytes.
- rx_full=1 at completion: rx_ovr pulse, no rx_we, done=1.
- clr asserted at edge 7, and separately rst low mid-byte:
  - no done/rx_we;
  - IDLE next cycle; reset outputs all 0;
  - a following byte transfers cleanly.
- With SPI_XFER_LSBF_EN, lsbf=1, tx 0x01: first MOSI bit is 1, and loopback gives rx_din=0x01.
